// File: rtl/auto_play_sequencer.sv
// Auto-play sequencer: walks the song ROM note by note, drives the tone generator's
// note code and reports song number and progress for the display and LEDs.

module auto_play_debounce #(
   parameter int unsigned CYCLES = 2_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic press
);
   localparam int unsigned      CNT_W    = (CYCLES < 2) ? 1 : $clog2(CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CYCLES - 1);

   logic             clean;
   logic [CNT_W-1:0] cnt;

   // cnt runs down only while raw disagrees with the clean level
   always_ff @(posedge clk) begin
      if (rst) begin
         clean <= 1'b0;
         cnt   <= CNT_LOAD;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (raw == clean) begin
            cnt <= CNT_LOAD;
         end else if (cnt == '0) begin
            clean <= raw;
            cnt   <= CNT_LOAD;
            press <= raw;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end
endmodule

// state    | meaning
// S_IDLE   | auto mode off, silent
// S_LOAD   | fetch ROM entry at note_idx (END advances the song)
// S_PLAY   | note sounding, beat_cnt running down
// S_GAP    | silent articulation gap, gap_cnt running down
// S_PAUSED | counters frozen, silent, ret_state holds PLAY or GAP
module auto_play_sequencer #(
   parameter int unsigned TICKS_PER_BEAT  = 25_000_000,
   parameter int unsigned GAP_TICKS       = 2_500_000,
   parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
   parameter int unsigned NUM_SONGS       = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       btn_prev,
   input  logic       btn_pause,
   input  logic       btn_next,
   output logic [4:0] note,
   output logic [1:0] song_num,
   output logic       playing,
   output logic [7:0] led
);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_PAUSED} state_t;

   localparam int unsigned      BEAT_W    = $clog2(7 * TICKS_PER_BEAT);
   localparam int unsigned      GAP_W     = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS);
   localparam logic [GAP_W-1:0] GAP_LOAD  = (GAP_TICKS == 0) ? '0 : GAP_W'(GAP_TICKS - 1);
   localparam logic [1:0]       SONG_LAST = 2'(NUM_SONGS - 1);

   state_t              state, state_nxt, ret_state;
   logic [4:0]          note_idx;
   logic [4:0]          cur_note;
   logic [BEAT_W-1:0]   beat_cnt, beat_load;
   logic [GAP_W-1:0]    gap_cnt;
   logic [7:0]          rom_word;
   logic [2:0]          beats_eff;
   logic                rom_end;
   logic [1:0]          song_inc, song_dec;
   logic                press_prev, press_pause, press_next;
   logic                active, ev_next, ev_prev, ev_pause, ev_resume;

   auto_play_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
      .clk(clk), .rst(rst), .raw(btn_prev), .press(press_prev));
   auto_play_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
      .clk(clk), .rst(rst), .raw(btn_pause), .press(press_pause));
   auto_play_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_next (
      .clk(clk), .rst(rst), .raw(btn_next), .press(press_next));

   // ROM entry {note[4:0], beats[2:0]}; note 31 marks END
   always_comb begin
      rom_word = {5'd31, 3'd0};
      case ({song_num, note_idx})
         {2'd0, 5'd0}: rom_word = {5'd8,  3'd1};
         {2'd0, 5'd1}: rom_word = {5'd9,  3'd1};
         {2'd0, 5'd2}: rom_word = {5'd10, 3'd1};
         {2'd0, 5'd3}: rom_word = {5'd11, 3'd1};
         {2'd0, 5'd4}: rom_word = {5'd12, 3'd1};
         {2'd0, 5'd5}: rom_word = {5'd13, 3'd1};
         {2'd0, 5'd6}: rom_word = {5'd14, 3'd1};
         {2'd1, 5'd0}: rom_word = {5'd15, 3'd2};
         {2'd1, 5'd1}: rom_word = {5'd12, 3'd1};
         {2'd1, 5'd2}: rom_word = {5'd10, 3'd0};
         {2'd1, 5'd3}: rom_word = {5'd0,  3'd1};
         {2'd1, 5'd4}: rom_word = {5'd8,  3'd3};
         {2'd2, 5'd0}: rom_word = {5'd21, 3'd1};
         {2'd2, 5'd1}: rom_word = {5'd19, 3'd1};
         {2'd2, 5'd2}: rom_word = {5'd17, 3'd2};
         {2'd2, 5'd3}: rom_word = {5'd1,  3'd1};
         {2'd2, 5'd4}: rom_word = {5'd5,  3'd2};
         default:      rom_word = {5'd31, 3'd0};
      endcase
   end

   assign rom_end   = (rom_word[7:3] == 5'd31);
   assign beats_eff = (rom_word[2:0] == 3'd0) ? 3'd1 : rom_word[2:0];
   assign beat_load = BEAT_W'(BEAT_W'(beats_eff) * BEAT_W'(TICKS_PER_BEAT) - BEAT_W'(1));
   assign song_inc  = (song_num == SONG_LAST) ? 2'd0 : song_num + 2'd1;
   assign song_dec  = (song_num == 2'd0) ? SONG_LAST : song_num - 2'd1;

   // presses ranked next > prev > pause, ignored while idle
   assign active    = enable && (state != S_IDLE);
   assign ev_next   = active && press_next;
   assign ev_prev   = active && !press_next && press_prev;
   assign ev_pause  = active && !press_next && !press_prev && press_pause &&
                      ((state == S_PLAY) || (state == S_GAP));
   assign ev_resume = active && !press_next && !press_prev && press_pause &&
                      (state == S_PAUSED);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!enable)                  state_nxt = S_IDLE;
      else if (state == S_IDLE)     state_nxt = S_LOAD;
      else if (ev_next || ev_prev)  state_nxt = S_LOAD;
      else if (ev_pause)            state_nxt = S_PAUSED;
      else if (ev_resume)           state_nxt = ret_state;
      else begin
         case (state)
            S_LOAD:  if (!rom_end)        state_nxt = S_PLAY;
            S_PLAY:  if (beat_cnt == '0)  state_nxt = S_GAP;
            S_GAP:   if (gap_cnt == '0)   state_nxt = S_LOAD;
            default:                      state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         song_num  <= 2'd0;
         note_idx  <= 5'd0;
         cur_note  <= 5'd0;
         beat_cnt  <= '0;
         gap_cnt   <= '0;
         ret_state <= S_IDLE;
      end else if (!enable || (state == S_IDLE)) begin
         note_idx <= 5'd0;
      end else if (ev_next || ev_prev) begin
         song_num <= ev_next ? song_inc : song_dec;
         note_idx <= 5'd0;
      end else if (ev_pause) begin
         ret_state <= state;
      end else if (!ev_resume) begin
         case (state)
            S_LOAD: begin
               if (rom_end) begin
                  note_idx <= 5'd0;
                  song_num <= song_inc;
               end else begin
                  cur_note <= rom_word[7:3];
                  beat_cnt <= beat_load;
               end
            end
            S_PLAY: begin
               if (beat_cnt == '0) gap_cnt  <= GAP_LOAD;
               else                beat_cnt <= beat_cnt - 1'b1;
            end
            S_GAP: begin
               if (gap_cnt == '0) note_idx <= note_idx + 1'b1;
               else               gap_cnt  <= gap_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // cur_note survives a pause, so resuming PLAY brings the same note back
   always_comb begin
      note    = (state == S_PLAY) ? cur_note : 5'd0;
      playing = (state == S_PLAY) || (state == S_GAP);
      led     = {playing, (state == S_PAUSED), 1'b0, note_idx};
   end
endmodule

// File: tb/tb_auto_play_sequencer.sv
// Bench for auto_play_sequencer: directed scenarios with literal expectations plus
// randomized button/enable/reset traffic checked every cycle against a song-level model.

module tb_auto_play_sequencer;
   localparam int TPB = 4;
   localparam int GAP = 1;
   localparam int DEB = 3;
   localparam int NS  = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       btn_prev = 1'b0;
   logic       btn_pause = 1'b0;
   logic       btn_next = 1'b0;
   logic [4:0] note;
   logic [1:0] song_num;
   logic       playing;
   logic [7:0] led;

   int total = 0;
   int bad   = 0;

   auto_play_sequencer #(
      .TICKS_PER_BEAT(TPB), .GAP_TICKS(GAP), .DEBOUNCE_CYCLES(DEB), .NUM_SONGS(NS)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .btn_prev(btn_prev), .btn_pause(btn_pause), .btn_next(btn_next),
      .note(note), .song_num(song_num), .playing(playing), .led(led)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- song-level reference model ----------------
   localparam int P_IDLE = 0, P_LOAD = 1, P_SOUND = 2, P_SILENT = 3, P_HOLD = 4;

   int song_len[3]      = '{7, 5, 5};
   int song_notes[3][7] = '{'{8, 9, 10, 11, 12, 13, 14},
                            '{15, 12, 10, 0, 8, 0, 0},
                            '{21, 19, 17, 1, 5, 0, 0}};
   int song_beats[3][7] = '{'{1, 1, 1, 1, 1, 1, 1},
                            '{2, 1, 0, 1, 3, 0, 0},
                            '{1, 1, 2, 1, 2, 0, 0}};

   int m_phase, m_resume, m_left, m_idx, m_song, m_cur;
   bit m_valid = 1'b0;
   bit m_press[3], m_clean[3], m_lvl[3], m_raw[3];
   int m_run[3];
   int exp_play;

   // index 0 = prev, 1 = pause, 2 = next
   always @(posedge clk) begin
      m_raw[0] = btn_prev;
      m_raw[1] = btn_pause;
      m_raw[2] = btn_next;
      if (rst) begin
         m_valid  = 1'b1;
         m_phase  = P_IDLE;
         m_resume = P_SOUND;
         m_song   = 0;
         m_idx    = 0;
         m_cur    = 0;
         m_left   = 0;
         for (int b = 0; b < 3; b++) begin
            m_press[b] = 1'b0;
            m_clean[b] = 1'b0;
            m_lvl[b]   = 1'b0;
            m_run[b]   = 0;
         end
      end else begin
         if (!enable) begin
            m_phase = P_IDLE;
            m_idx   = 0;
         end else if (m_phase == P_IDLE) begin
            m_phase = P_LOAD;
            m_idx   = 0;
         end else if (m_press[2]) begin
            m_song  = (m_song + 1) % NS;
            m_idx   = 0;
            m_phase = P_LOAD;
         end else if (m_press[0]) begin
            m_song  = (m_song + NS - 1) % NS;
            m_idx   = 0;
            m_phase = P_LOAD;
         end else if (m_press[1] && (m_phase == P_SOUND || m_phase == P_SILENT)) begin
            m_resume = m_phase;
            m_phase  = P_HOLD;
         end else if (m_press[1] && m_phase == P_HOLD) begin
            m_phase = m_resume;
         end else if (m_phase == P_LOAD) begin
            if (m_idx >= song_len[m_song]) begin
               m_idx  = 0;
               m_song = (m_song + 1) % NS;
            end else begin
               m_cur   = song_notes[m_song][m_idx];
               m_left  = ((song_beats[m_song][m_idx] == 0) ? 1 : song_beats[m_song][m_idx]) * TPB;
               m_phase = P_SOUND;
            end
         end else if (m_phase == P_SOUND) begin
            if (m_left == 1) begin
               m_phase = P_SILENT;
               m_left  = (GAP > 0) ? GAP : 1;
            end else m_left--;
         end else if (m_phase == P_SILENT) begin
            if (m_left == 1) begin
               m_idx   = (m_idx + 1) % 32;
               m_phase = P_LOAD;
            end else m_left--;
         end
         // a level held for DEB samples becomes the clean level; rising edge = press
         for (int b = 0; b < 3; b++) begin
            m_press[b] = 1'b0;
            if (m_run[b] == 0 || m_raw[b] != m_lvl[b]) begin
               m_lvl[b] = m_raw[b];
               m_run[b] = 1;
            end else m_run[b]++;
            if (m_run[b] >= DEB && m_lvl[b] != m_clean[b]) begin
               m_clean[b] = m_lvl[b];
               m_press[b] = m_lvl[b];
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         exp_play = (m_phase == P_SOUND || m_phase == P_SILENT) ? 1 : 0;
         chk("cmp_note", note, (m_phase == P_SOUND) ? m_cur : 0);
         chk("cmp_song", song_num, m_song);
         chk("cmp_playing", playing, exp_play);
         chk("cmp_led", led, exp_play * 128 + ((m_phase == P_HOLD) ? 64 : 0) + m_idx);
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_btn(input int which, input logic v);
      case (which)
         0:       btn_prev  = v;
         1:       btn_pause = v;
         default: btn_next  = v;
      endcase
   endtask

   task automatic press_btn(input int which);
      set_btn(which, 1'b1);
      wait_n(5);
      set_btn(which, 1'b0);
      wait_n(8);
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0;
      btn_prev = 1'b0; btn_pause = 1'b0; btn_next = 1'b0;
      wait_n(2);
      chk("rst_note", note, 0);
      chk("rst_song", song_num, 0);
      chk("rst_playing", playing, 0);
      chk("rst_led", led, 0);
      rst = 1'b0;
   endtask

   int r;

   initial begin
      // song 0 playback timing and END wrap
      do_reset();
      enable = 1'b1;
      wait_n(1);  chk("t1_load_note", note, 0);   chk("t1_load_play", playing, 0);
      wait_n(1);  chk("t1_first_note", note, 8);  chk("t1_first_led", led, 8'h80);
      wait_n(3);  chk("t1_last_beat", note, 8);
      wait_n(1);  chk("t1_gap_note", note, 0);    chk("t1_gap_play", playing, 1);
      wait_n(1);  chk("t1_load2_play", playing, 0); chk("t1_load2_led", led, 8'h01);
      wait_n(1);  chk("t1_second_note", note, 9); chk("t1_second_led", led, 8'h81);
      wait_n(35); chk("t1_idx7_led", led, 8'h07); chk("t1_idx7_song", song_num, 0);
      wait_n(1);  chk("t1_end_song", song_num, 1); chk("t1_end_led", led, 0);
      wait_n(1);  chk("t1_song1_note", note, 15);

      // debounce: short press ignored, long press counts once
      btn_next = 1'b1; wait_n(2); btn_next = 1'b0; wait_n(8);
      chk("t2_short_song", song_num, 1);
      btn_next = 1'b1; wait_n(3);
      chk("t2_before_press", song_num, 1);
      wait_n(1);
      chk("t2_press_song", song_num, 2); chk("t2_press_led", led, 0); chk("t2_press_note", note, 0);
      wait_n(1); btn_next = 1'b0; wait_n(8);
      chk("t2_single_press", song_num, 2);

      // song wrap in both directions
      press_btn(2); chk("t3_next_wrap", song_num, 0);
      press_btn(0); chk("t3_prev_wrap", song_num, 2);
      press_btn(2); chk("t3_next_a", song_num, 0);
      press_btn(2); chk("t3_next_b", song_num, 1);
      press_btn(2); chk("t3_next_c", song_num, 2);

      // pause with beat counter at 2, hold, resume
      do_reset();
      enable = 1'b1; btn_pause = 1'b1;
      wait_n(2); chk("t4_note_a", note, 8);
      wait_n(1); chk("t4_note_b", note, 8); chk("t4_led_b", led, 8'h80);
      wait_n(1); chk("t4_paused_note", note, 0); chk("t4_paused_led", led, 8'h40);
      chk("t4_paused_play", playing, 0);
      wait_n(1); btn_pause = 1'b0;
      for (int i = 0; i < 19; i++) begin
         chk("t4_hold_note", note, 0);
         chk("t4_hold_led", led, 8'h40);
         wait_n(1);
      end
      btn_pause = 1'b1;
      wait_n(3); chk("t4_still_paused", led, 8'h40);
      wait_n(1); chk("t4_resume_1", note, 8); chk("t4_resume_led", led, 8'h80);
      wait_n(1); chk("t4_resume_2", note, 8); btn_pause = 1'b0;
      wait_n(1); chk("t4_resume_3", note, 8);
      wait_n(1); chk("t4_after_note", note, 0); chk("t4_after_play", playing, 1);
      wait_n(1); chk("t4_next_idx", led, 8'h01);

      // next and pause together: next wins
      wait_n(1); chk("t5_note9", note, 9);
      btn_next = 1'b1; btn_pause = 1'b1;
      wait_n(4); chk("t5_song", song_num, 1); chk("t5_led", led, 0);
      wait_n(1); btn_next = 1'b0; btn_pause = 1'b0;
      wait_n(8); chk("t5_not_paused", led & 8'h40, 0); chk("t5_song_kept", song_num, 1);

      // enable dropped mid-note, then reset racing a press
      wait_n(3); chk("t6_note12", note, 12);
      enable = 1'b0;
      wait_n(1);
      chk("t6_off_note", note, 0); chk("t6_off_play", playing, 0);
      chk("t6_off_led", led, 0);   chk("t6_off_song", song_num, 1);
      enable = 1'b1; btn_next = 1'b1;
      wait_n(3); rst = 1'b1;
      wait_n(1);
      chk("t6_rst_note", note, 0); chk("t6_rst_song", song_num, 0);
      chk("t6_rst_play", playing, 0); chk("t6_rst_led", led, 0);
      rst = 1'b0; btn_next = 1'b0;

      // randomized traffic
      for (int it = 0; it < 350; it++) begin
         r = int'($urandom_range(0, 99));
         rst       = (r < 3);
         enable    = !(r >= 3 && r < 12);
         btn_prev  = ($urandom_range(0, 9) == 0);
         btn_pause = ($urandom_range(0, 6) == 0);
         btn_next  = ($urandom_range(0, 9) == 0);
         wait_n(int'($urandom_range(1, 7)));
         rst = 1'b0; enable = 1'b1;
         btn_prev = 1'b0; btn_pause = 1'b0; btn_next = 1'b0;
         wait_n(int'($urandom_range(0, 40)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
